// File: rtl/fifo_rd_sched.sv
// Read-side scheduler: round-robin, burst-limited arbitration of NCH async-FIFO
// read ports into one registered valid/ready output stage in the rclk domain.
module fifo_rd_sched #(
    parameter int NCH   = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH-1:0]       rempty,
    input  logic [NCH*DSIZE-1:0] rdata,
    output logic [NCH-1:0]       rinc,
    output logic                 m_valid,
    output logic [DSIZE-1:0]     m_data,
    output logic [CW-1:0]        m_ch,
    input  logic                 m_ready,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0]    BURST_C  = 8'(BURST);
    localparam logic [CW-1:0] LAST_RST = CW'(NCH - 1);
    localparam logic [CW:0]   NCH_C    = (CW+1)'(NCH);

    state_t           state_q, state_d;
    logic [CW-1:0]    g_q, g_d;
    logic [CW-1:0]    last_q, last_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [DSIZE-1:0] m_data_q, m_data_d;
    logic [CW-1:0]    m_ch_q, m_ch_d;

    logic [NCH-1:0]   cand;
    logic             slot_free;
    logic             pop;
    logic             hit;
    logic [CW-1:0]    win;
    logic [CW:0]      rr_sum;
    logic [CW-1:0]    rr_idx;
    logic [DSIZE-1:0] g_data;

    assign cand      = ch_en & ~rempty;
    assign slot_free = !m_valid_q || m_ready;
    assign pop       = (state_q == GRANT) && slot_free && !rempty[g_q]
                       && ch_en[g_q] && (beat_cnt_q < BURST_C);

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;
    assign busy    = (state_q == GRANT);

    // Round-robin search for the first candidate after the last grant
    always_comb begin
        hit    = 1'b0;
        win    = '0;
        rr_sum = '0;
        rr_idx = '0;
        for (int k = 1; k <= NCH; k++) begin
            rr_sum = {1'b0, last_q} + (CW+1)'(k);
            if (rr_sum >= NCH_C) begin
                rr_sum = rr_sum - NCH_C;
            end
            rr_idx = rr_sum[CW-1:0];
            if (!hit && cand[rr_idx]) begin
                hit = 1'b1;
                win = rr_idx;
            end
        end
    end

    // Select read data of the granted channel
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (g_q == CW'(i)) begin
                g_data = rdata[i*DSIZE +: DSIZE];
            end
        end
    end

    // One-hot pop strobe toward the granted FIFO
    always_comb begin
        rinc = '0;
        if (pop) begin
            rinc[g_q] = 1'b1;
        end
    end

    // Next state: grant search, burst counting, output stage load/drain
    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_ch_d     = m_ch_q;

        if (pop) begin
            m_valid_d  = 1'b1;
            m_data_d   = g_data;
            m_ch_d     = g_q;
            beat_cnt_d = beat_cnt_q + 8'd1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d    = GRANT;
                    g_d        = win;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!pop && (rempty[g_q] || !ch_en[g_q]
                             || beat_cnt_q == BURST_C)) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= IDLE;
            g_q        <= '0;
            last_q     <= LAST_RST;
            beat_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_ch_q     <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_ch_q     <= m_ch_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: FIFO queues model, round-robin grant model,
// scoreboard of popped words checked by an independent output monitor.
module tb_fifo_rd_sched;

    localparam int NCH   = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 64;

    logic                 rclk = 1'b0;
    logic                 rrst_n = 1'b0;
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       rempty;
    logic [NCH*DSIZE-1:0] rdata;
    logic [NCH-1:0]       rinc;
    logic                 m_valid;
    logic [DSIZE-1:0]     m_data;
    logic [CW-1:0]        m_ch;
    logic                 m_ready;
    logic                 busy;

    fifo_rd_sched #(
        .NCH   (NCH),
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .ch_en   (ch_en),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ch    (m_ch),
        .m_ready (m_ready),
        .busy    (busy)
    );

    always #5 rclk = ~rclk;

    logic [DSIZE-1:0]    mem [NCH][DEPTH];
    int                  wp [NCH];
    int                  rp [NCH];
    logic [NCH-1:0]      pend;
    logic [CW+DSIZE-1:0] sb [$];
    logic [CW+DSIZE-1:0] mon_want;
    int                  gseq [$];
    int                  plens [$];
    int                  passed = 0;
    int                  total = 0;

    int               mlast;
    int               cur_g;
    int               pops;
    logic             p_busy;
    logic             p_bp;
    logic [NCH-1:0]   p_rinc;
    logic [NCH-1:0]   p_cand;
    logic [DSIZE-1:0] p_data;
    logic [CW-1:0]    p_ch;

    logic [NCH-1:0]   s_rinc;
    logic             s_busy;
    logic             s_mvalid;
    logic [DSIZE-1:0] s_mdata;
    logic [CW-1:0]    s_mch;

    task automatic chk(input bit ok, input string nm,
                       input int act, input int want);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    endtask

    function automatic int fsize(input int i);
        return wp[i] - rp[i];
    endfunction

    function automatic int words_left();
        int n;
        n = 0;
        for (int i = 0; i < NCH; i++) n += fsize(i);
        return n;
    endfunction

    function automatic void drive_fifo();
        for (int i = 0; i < NCH; i++) begin
            rempty[i] = (fsize(i) == 0);
            rdata[i*DSIZE +: DSIZE] =
                (fsize(i) == 0) ? '0 : mem[i][rp[i] % DEPTH];
        end
    endfunction

    function automatic void push(input int ch, input logic [DSIZE-1:0] d);
        mem[ch][wp[ch] % DEPTH] = d;
        wp[ch]++;
        drive_fifo();
    endfunction

    function automatic int rr_pick(input int lst, input logic [NCH-1:0] c);
        for (int k = 1; k <= NCH; k++)
            if (c[(lst + k) % NCH]) return (lst + k) % NCH;
        return -1;
    endfunction

    // Per-cycle rule checks and grant tracking at the falling edge
    task automatic sample_check();
        logic [NCH-1:0] cand;
        logic [NCH-1:0] oh;
        bit             stop_now;
        int             eg;
        cand     = ch_en & ~rempty;
        s_rinc   = rinc;
        s_busy   = busy;
        s_mvalid = m_valid;
        s_mdata  = m_data;
        s_mch    = m_ch;

        chk($onehot0(rinc), "rinc_onehot", int'(rinc), 0);
        for (int i = 0; i < NCH; i++)
            if (rinc[i])
                chk(cand[i], "rinc_target", int'(rinc), int'(cand));
        if (rinc != 0)
            chk(!(m_valid && !m_ready), "rinc_backpressure",
                int'(rinc), 0);
        if (!busy) chk(rinc == 0, "rinc_idle", int'(rinc), 0);
        if (p_bp)
            chk(m_valid && m_data == p_data && m_ch == p_ch, "hold",
                int'({m_valid, m_ch, m_data}), int'({1'b1, p_ch, p_data}));

        if (p_busy) begin
            stop_now = (p_rinc == 0) && (!p_cand[cur_g] || pops == BURST);
            chk(busy == !stop_now, "grant_exit", int'(busy), int'(!stop_now));
            if (!busy) begin
                mlast = cur_g;
                plens.push_back(pops);
            end
        end else begin
            chk(busy == (p_cand != 0), "idle_grant", int'(busy),
                int'(p_cand != 0));
            if (busy) begin
                eg = rr_pick(mlast, p_cand);
                if (eg < 0) eg = 0;
                cur_g = eg;
                pops = 0;
                gseq.push_back(eg);
            end
        end

        if (busy && rinc != 0) begin
            oh = '0;
            oh[cur_g] = 1'b1;
            chk(rinc == oh, "rinc_channel", int'(rinc), int'(oh));
            pops++;
            chk(pops <= BURST, "burst_limit", pops, BURST);
        end

        pend = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rinc[i] && fsize(i) > 0) begin
                pend[i] = 1'b1;
                sb.push_back({CW'(i), mem[i][rp[i] % DEPTH]});
            end
        end

        p_busy = busy;
        p_rinc = rinc;
        p_cand = cand;
        p_bp   = m_valid && !m_ready;
        p_data = m_data;
        p_ch   = m_ch;
    endtask

    task automatic cycle();
        @(negedge rclk);
        if (rrst_n) sample_check();
        @(posedge rclk);
        #1;
        for (int i = 0; i < NCH; i++) if (pend[i]) rp[i]++;
        pend = '0;
        drive_fifo();
    endtask

    task automatic do_reset(input bit clear);
        rrst_n = 1'b0;
        #1;
        chk(m_valid == 1'b0, "rst_mvalid", int'(m_valid), 0);
        chk(rinc == 0, "rst_rinc", int'(rinc), 0);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        pend = '0;
        sb.delete();
        gseq.delete();
        plens.delete();
        mlast = NCH - 1;
        cur_g = 0;
        pops = 0;
        p_busy = 1'b0;
        p_bp = 1'b0;
        p_rinc = '0;
        p_cand = '0;
        if (clear) for (int i = 0; i < NCH; i++) rp[i] = wp[i];
        drive_fifo();
        m_ready = 1'b1;
        ch_en = '1;
        repeat (2) @(posedge rclk);
        #1;
        chk(m_data == 0 && m_ch == 0, "rst_out", int'({m_ch, m_data}), 0);
        rrst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        ch_en = '1;
        m_ready = 1'b1;
        while (n < 1000 && (words_left() != 0 || sb.size() != 0)) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        chk(words_left() == 0 && sb.size() == 0, nm,
            words_left() + sb.size(), 0);
    endtask

    // Output monitor: every accepted beat must match the oldest popped word
    always @(negedge rclk) begin
        if (rrst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk(1'b0, "beat_unexpected", int'({m_ch, m_data}), 0);
            end else begin
                mon_want = sb.pop_front();
                chk({m_ch, m_data} == mon_want, "beat",
                    int'({m_ch, m_data}), int'(mon_want));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        int cnt2;
        logic [NCH-1:0] wr;
        for (int i = 0; i < NCH; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        ch_en = '1;
        m_ready = 1'b1;
        pend = '0;
        drive_fifo();
        do_reset(1'b1);

        // single channel, three words
        push(1, 8'hA1);
        push(1, 8'hA2);
        push(1, 8'hA3);
        for (int c = 0; c < 6; c++) begin
            cycle();
            wr = (c >= 1 && c <= 3) ? 4'b0010 : 4'b0000;
            if (c < 5) chk(s_rinc == wr, "t1_rinc", int'(s_rinc), int'(wr));
            if (c >= 2 && c <= 4)
                chk(s_mvalid && s_mch == 2'd1
                    && s_mdata == 8'(8'hA1 + c - 2), "t1_data",
                    int'({s_mvalid, s_mch, s_mdata}),
                    int'({1'b1, 2'd1, 8'(8'hA1 + c - 2)}));
        end
        chk(s_busy == 1'b0, "t1_idle", int'(s_busy), 0);
        push(0, 8'hB0);
        push(2, 8'hB2);
        n = 0;
        s_rinc = '0;
        while (n < 6 && s_rinc == 0) begin
            cycle();
            n++;
        end
        chk(s_rinc == 4'b0100, "t1_after_last", int'(s_rinc), 4);
        drain("t1_drain");

        // all channels loaded, full bursts
        do_reset(1'b1);
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < 10; j++) push(i, 8'(i * 16 + j));
        repeat (80) cycle();
        for (int j = 0; j < 5; j++)
            chk(gseq.size() > j && gseq[j] == j % NCH, "t2_order",
                (gseq.size() > j) ? gseq[j] : -1, j % NCH);
        for (int j = 0; j < 4; j++)
            chk(plens.size() > j && plens[j] == BURST, "t2_burst_len",
                (plens.size() > j) ? plens[j] : -1, BURST);
        drain("t2_drain");

        // backpressure on channel 0
        do_reset(1'b1);
        for (int j = 0; j < 4; j++) push(0, 8'(8'hC0 + j));
        n = 0;
        s_mvalid = 1'b0;
        while (n < 10 && !s_mvalid) begin
            cycle();
            n++;
        end
        chk(s_mvalid, "t3_first_beat", int'(s_mvalid), 1);
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk(s_mvalid && s_mdata == 8'hC1 && s_rinc == 0, "t3_frozen",
                int'({s_rinc, s_mvalid, s_mdata}), int'({4'b0, 1'b1, 8'hC1}));
        end
        m_ready = 1'b1;
        cycle();
        chk(s_rinc == 4'b0001, "t3_resume", int'(s_rinc), 1);
        drain("t3_drain");

        // channel 2 masked
        do_reset(1'b1);
        ch_en = 4'b1011;
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < 6; j++) push(i, 8'(8'h40 + i * 8 + j));
        cnt2 = 0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (s_rinc[2]) cnt2++;
        end
        chk(cnt2 == 0, "t4_no_ch2", cnt2, 0);
        for (int j = 0; j < 4; j++) begin
            k = (j == 2) ? 3 : j % 3;
            chk(gseq.size() > j && gseq[j] == k, "t4_order",
                (gseq.size() > j) ? gseq[j] : -1, k);
        end
        drain("t4_drain");

        // disable granted channel mid-burst
        do_reset(1'b1);
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < 8; j++) push(i, 8'((i + 1) * 16 + j));
        n = 0;
        k = 0;
        while (k < 2 && n < 12) begin
            cycle();
            n++;
            if (s_rinc != 0) k++;
        end
        chk(k == 2, "t5_two_pops", k, 2);
        m_ready = 1'b0;
        ch_en = 4'b1110;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk(s_rinc[0] == 1'b0, "t5_no_rinc", int'(s_rinc), 0);
            if (c == 1) chk(s_busy == 1'b0, "t5_idle", int'(s_busy), 0);
        end
        chk(s_mvalid && s_mdata == 8'h11 && s_mch == 2'd0, "t5_held",
            int'({s_mvalid, s_mch, s_mdata}), int'({1'b1, 2'd0, 8'h11}));
        m_ready = 1'b1;
        cycle();
        chk(s_mvalid && s_mdata == 8'h11 && s_mch == 2'd0, "t5_delivered",
            int'({s_mvalid, s_mch, s_mdata}), int'({1'b1, 2'd0, 8'h11}));
        drain("t5_drain");

        // reset in the middle of a burst
        do_reset(1'b1);
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < 8; j++) push(i, 8'(8'h80 + i * 8 + j));
        n = 0;
        s_mvalid = 1'b0;
        while (n < 10 && !(s_mvalid && s_busy)) begin
            cycle();
            n++;
        end
        m_ready = 1'b0;
        chk(m_valid == 1'b1, "t6_pre_valid", int'(m_valid), 1);
        do_reset(1'b0);
        n = 0;
        while (n < 10 && gseq.size() == 0) begin
            cycle();
            n++;
        end
        chk(gseq.size() > 0 && gseq[0] == 0, "t6_first_grant",
            (gseq.size() > 0) ? gseq[0] : -1, 0);
        drain("t6_drain");

        // randomized traffic against the model
        do_reset(1'b1);
        for (int i = 0; i < NCH; i++) begin
            n = $urandom_range(0, 12);
            for (int j = 0; j < n; j++) push(i, DSIZE'($urandom));
        end
        for (int c = 0; c < 800; c++) begin
            cycle();
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) ch_en = NCH'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, NCH - 1);
                if (fsize(k) < DEPTH - 4) push(k, DSIZE'($urandom));
            end
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
